// File: rtl/intc_pkg.sv
// Shared constants, register-select type and address decoder for the interrupt controller.
package intc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] INTC_EN_ADDR    = 32'h1000_0200;
  localparam logic [ADDR_W-1:0] INTC_PEND_ADDR  = 32'h1000_0204;
  localparam logic [ADDR_W-1:0] INTC_CLAIM_ADDR = 32'h1000_0208;

  localparam int INTC_CLAIM_VALID_BIT = 31;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_EN,
    REG_PEND,
    REG_CLAIM
  } intcReg_e;

  function automatic intcReg_e decodeAddr(input logic [ADDR_W-1:0] addr);
    intcReg_e sel;
    case (addr)
      INTC_EN_ADDR:    sel = REG_EN;
      INTC_PEND_ADDR:  sel = REG_PEND;
      INTC_CLAIM_ADDR: sel = REG_CLAIM;
      default:         sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: reports whether any request is active and the lowest active index.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 5
) (
  input  logic [N_SRC-1:0] i_act,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_id
);

  // Scanning from the top down lets the lowest set index overwrite the others.
  always_comb begin
    o_valid = |i_act;
    o_id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_act[i]) begin
        o_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intc.sv
// Memory-mapped interrupt controller: edge-detects peripheral requests into pending bits,
// masks them, and presents the lowest-index active source to the core.
module intc
  import intc_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  irq_src_i,
  input  logic [ADDR_W-1:0] intc_r_addr_i,
  input  logic [ADDR_W-1:0] intc_w_addr_i,
  input  logic [DATA_W-1:0] intc_data_i,
  input  logic              intc_r_enable_i,
  input  logic              intc_w_enable_i,
  output logic [DATA_W-1:0] intc_data_o,
  output logic              irq_o,
  output logic [ID_W-1:0]   irq_id_o,
  input  logic              irq_ack_i
);

  logic [N_SRC-1:0]  r_en;
  logic [N_SRC-1:0]  r_pend;
  logic [N_SRC-1:0]  r_srcQ;

  logic [N_SRC-1:0]  w_rise;
  logic [N_SRC-1:0]  w_act;
  logic              w_winValid;
  logic [ID_W-1:0]   w_winId;
  intcReg_e          w_rdSel;
  intcReg_e          w_wrSel;
  logic [N_SRC-1:0]  w_w1cMask;
  logic [N_SRC-1:0]  w_claimMask;
  logic [N_SRC-1:0]  w_ackMask;
  logic [N_SRC-1:0]  w_pendNext;
  logic [DATA_W-1:0] w_claimData;
  logic [DATA_W-1:0] w_rdData;
  logic              w_rdHit;
  logic              w_unusedData;

  assign w_rise = irq_src_i & ~r_srcQ;
  assign w_act  = r_pend & r_en;

  assign w_rdSel = intc_r_enable_i ? decodeAddr(intc_r_addr_i) : REG_NONE;
  assign w_wrSel = intc_w_enable_i ? decodeAddr(intc_w_addr_i) : REG_NONE;

  // One encoder serves both the claim read and the registered request id.
  intc_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prioEnc (
    .i_act   (w_act),
    .o_valid (w_winValid),
    .o_id    (w_winId)
  );

  assign w_w1cMask   = (w_wrSel == REG_PEND) ? intc_data_i[N_SRC-1:0] : '0;
  assign w_claimMask = ((w_rdSel == REG_CLAIM) && w_winValid) ? (N_SRC'(1) << w_winId) : '0;
  assign w_ackMask   = (irq_ack_i && irq_o) ? (N_SRC'(1) << irq_id_o) : '0;

  // A new rising edge always beats any clear arriving in the same cycle.
  assign w_pendNext = (r_pend & ~(w_w1cMask | w_claimMask | w_ackMask)) | w_rise;

  assign w_unusedData = ^intc_data_i;

  always_comb begin
    w_claimData                       = '0;
    w_claimData[ID_W-1:0]             = w_winId;
    w_claimData[INTC_CLAIM_VALID_BIT] = w_winValid;
  end

  always_comb begin
    w_rdHit  = 1'b1;
    w_rdData = '0;
    case (w_rdSel)
      REG_EN:    w_rdData = DATA_W'(r_en);
      REG_PEND:  w_rdData = DATA_W'(r_pend);
      REG_CLAIM: w_rdData = w_claimData;
      default:   w_rdHit  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en        <= '0;
      r_pend      <= '0;
      r_srcQ      <= '0;
      irq_o       <= 1'b0;
      irq_id_o    <= '0;
      intc_data_o <= '0;
    end else begin
      r_srcQ   <= irq_src_i;
      r_pend   <= w_pendNext;
      irq_o    <= w_winValid;
      irq_id_o <= w_winId;
      if (w_wrSel == REG_EN) begin
        r_en <= intc_data_i[N_SRC-1:0];
      end
      if (w_rdHit) begin
        intc_data_o <= w_rdData;
      end
    end
  end

endmodule
